arb_grant_mux: RTL and testbench

//  Downstream consumer of the round-robin arbiter's one-hot grant. Locks onto the granted client and

---
 rtl/arb_mux_pkg.sv | 25 ++
 rtl/arb_out_reg.sv | 36 +++
 rtl/arb_grant_mux.sv | 135 +++++++++++++
 tb/tb_arb_grant_mux.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared state type, constants and grant decode helper for arb_grant_mux
package arb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int RELEASE_CYCLES = 2;
  localparam int TIMEOUT_CYCLES = 15;
  localparam int MAX_CLIENTS    = 32;
  localparam int IDX_W          = 5;

  // Lowest set bit wins, so an illegal multi-hot grant still resolves deterministically.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CLIENTS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CLIENTS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_out_reg.sv
// rtl/arb_out_reg.sv - single-entry valid/ready output register carrying data, last and source
module arb_out_reg #(
  parameter int DATA_W = 32,
  parameter int SRC_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [SRC_W-1:0]  in_src,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [SRC_W-1:0]  m_src
);

  // The caller only loads when the slot is empty or draining, so a load always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_src   <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= in_data;
      m_last  <= in_last;
      m_src   <= in_src;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/arb_grant_mux.sv
// rtl/arb_grant_mux.sv - locks onto the arbiter grant and muxes that client's packet onto one stream
// Optional idle timeout in LOCK is enabled by defining ARB_GRANT_MUX_TIMEOUT_EN.
module arb_grant_mux
  import arb_mux_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = 32,
  parameter int MAX_BEATS   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        grant,
  output logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        c_valid,
  input  logic [NUM_CLIENTS*DATA_W-1:0] c_data,
  input  logic [NUM_CLIENTS-1:0]        c_last,
  output logic [NUM_CLIENTS-1:0]        c_ready,
  output logic                          m_valid,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_last,
  output logic [$clog2(NUM_CLIENTS)-1:0] m_src,
  input  logic                          m_ready,
  output logic                          trunc_err
);

  localparam int SRC_W = $clog2(NUM_CLIENTS);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_e                   state, state_n;
  logic [SRC_W-1:0]         owner;
  logic [CNT_W-1:0]         beat_cnt;
  logic [1:0]               rel_cnt;
  logic [MAX_CLIENTS-1:0]   grant_ext;
  logic [NUM_CLIENTS-1:0]   rel_mask;
  logic [DATA_W-1:0]        sel_data;
  logic                     sel_valid, sel_last, at_max;
  logic                     load, trunc_n, timeout_hit;

  always_comb begin
    grant_ext                  = '0;
    grant_ext[NUM_CLIENTS-1:0] = grant;
  end

  assign sel_valid = c_valid[owner];
  assign sel_last  = c_last[owner];
  assign sel_data  = c_data[owner*DATA_W +: DATA_W];
  assign at_max    = (beat_cnt == CNT_W'(MAX_BEATS - 1));

  // Masking the finished owner during RELEASE is what makes the arbiter rotate away.
  assign rel_mask = (state == RELEASE) ? (NUM_CLIENTS'(1) << owner) : '0;
  assign req      = rst_n ? (c_valid & ~rel_mask) : '0;

`ifdef ARB_GRANT_MUX_TIMEOUT_EN
  logic [3:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != LOCK || sel_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 4'd1;
    end
  end

  assign timeout_hit = (state == LOCK) & ~sel_valid & (idle_cnt == 4'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    c_ready = '0;
    load    = 1'b0;
    trunc_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (|grant) state_n = LOCK;
      end
      LOCK: begin
        c_ready[owner] = ~m_valid | m_ready;
        load           = sel_valid & (~m_valid | m_ready);
        if (load & (sel_last | at_max)) begin
          trunc_n = ~sel_last;
          state_n = RELEASE;
        end else if (timeout_hit) begin
          trunc_n = 1'b1;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (rel_cnt == 2'(RELEASE_CYCLES - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      beat_cnt  <= '0;
      rel_cnt   <= '0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_n;
      trunc_err <= trunc_n;
      if (state == IDLE && |grant) owner <= SRC_W'(onehot_to_idx(grant_ext));
      if (state == LOCK && state_n == RELEASE) begin
        beat_cnt <= '0;
      end else if (load) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      rel_cnt <= (state == RELEASE) ? rel_cnt + 2'd1 : 2'd0;
    end
  end

  arb_out_reg #(
    .DATA_W (DATA_W),
    .SRC_W  (SRC_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .in_data (sel_data),
    .in_last (sel_last | at_max),
    .in_src  (owner),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_src   (m_src)
  );

endmodule

// File: tb/tb_arb_grant_mux.sv
// tb/tb_arb_grant_mux.sv - randomized scoreboard bench for arb_grant_mux
`timescale 1ns/1ps
module tb_arb_grant_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    grant, req, c_valid, c_last, c_ready;
  logic [N*DW-1:0] c_data;
  logic            m_valid, m_last, m_ready, trunc_err;
  logic [DW-1:0]   m_data;
  logic [SW-1:0]   m_src;

  arb_grant_mux #(.NUM_CLIENTS(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant     (grant),
    .req       (req),
    .c_valid   (c_valid),
    .c_data    (c_data),
    .c_last    (c_last),
    .c_ready   (c_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_src     (m_src),
    .m_ready   (m_ready),
    .trunc_err (trunc_err)
  );

  always #5 clk = ~clk;

  beat_t cq[N][$];
  beat_t eq[N][$];
  int    pos[N] = '{default: 0};
  int    tests = 0, fails = 0;
  int    exp_trunc = 0, seen_trunc = 0;
  bit    use_arb = 1'b0, bub_en = 1'b0, sb_en = 1'b0;
  int    mr_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the output stream per client is its input stream, cut after c_last or MB beats.
  task automatic add_packet(input int c, input int len);
    beat_t b, e;
    for (int k = 0; k < len; k++) begin
      b.data = $urandom;
      b.last = (k == len - 1);
      cq[c].push_back(b);
      pos[c]++;
      e = b;
      if (b.last || pos[c] == MB) begin
        if (!b.last) exp_trunc++;
        e.last = 1'b1;
        pos[c] = 0;
      end
      eq[c].push_back(e);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (eq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin : driver
    logic [N-1:0] hs, req_s, cv_s, gbase, extra;
    int cur;
    cur = 0; gbase = '0; extra = '0;
    grant = '0; c_valid = '0; c_last = '0; c_data = '0; m_ready = 1'b0;
    forever begin
      @(negedge clk);
      hs = c_valid & c_ready; req_s = req; cv_s = c_valid;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) void'(cq[i].pop_front());
        if (cq[i].size() > 0 && !(bub_en && $urandom_range(3) == 0)) begin
          c_valid[i] = 1'b1;
          c_data[i*DW +: DW] = cq[i][0].data;
          c_last[i] = cq[i][0].last;
        end else begin
          c_valid[i] = 1'b0;
          c_last[i] = 1'b0;
          c_data[i*DW +: DW] = '0;
        end
      end
      case (mr_mode)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom_range(3) != 0);
        default: m_ready = 1'b0;
      endcase
      if (use_arb) begin
        if (!(gbase != '0 && req_s[cur])) begin
          gbase = '0; extra = '0;
          for (int k = 1; k <= N; k++) begin
            if (gbase == '0 && req_s[(cur + k) % N]) begin
              cur = (cur + k) % N;
              gbase = N'(1) << cur;
            end
          end
          // Occasionally add a higher idle client to make the grant multi-hot.
          if (gbase != '0 && $urandom_range(2) == 0)
            for (int j = cur + 1; j < N; j++)
              if (extra == '0 && !cv_s[j]) extra = N'(1) << j;
        end
        grant = gbase | extra;
      end
    end
  end

  initial begin : monitor
    logic pv, pr, pl;
    logic [DW-1:0] pd;
    logic [SW-1:0] ps;
    beat_t e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; ps = '0;
    forever begin
      @(negedge clk);
      if (sb_en && rst_n) begin
        check("c_ready_onehot", 64'($countones(c_ready) <= 1), 64'd1);
        if (m_valid && !m_ready) check("c_ready_stall", 64'(c_ready), 64'd0);
        if (pv && !pr)
          check("out_hold", 64'({m_valid, m_data, m_last, m_src}), 64'({1'b1, pd, pl, ps}));
        if (trunc_err) begin
          seen_trunc++;
          check("trunc_with_last", 64'(m_valid & m_last), 64'd1);
        end
        if (m_valid && m_ready) begin
          if (eq[m_src].size() == 0) begin
            check("unexpected_beat", 64'(m_src), 64'hFF);
          end else begin
            e = eq[m_src].pop_front();
            check("beat_data", 64'(m_data), 64'(e.data));
            check("beat_last", 64'(m_last), 64'(e.last));
          end
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last; ps = m_src;
    end
  end

  initial begin : main
    int cyc;
    add_packet(3, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 64'(req), 64'd0);
    check("rst_c_ready", 64'(c_ready), 64'd0);
    check("rst_out", 64'({m_valid, m_data, m_last, m_src, trunc_err}), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    sb_en = 1'b1;

    // Three-beat packet from client 1, then a second packet to keep req[1] visible.
    add_packet(1, 3); add_packet(1, 1);
    repeat (2) @(posedge clk);
    #2 grant = 4'b0010;
    @(negedge clk);
    check("t1_n_ready", 64'({c_ready, m_valid}), 64'd0);
    @(posedge clk); #2 grant = '0;
    @(negedge clk);
    check("t1_n1_ready", 64'({c_ready, m_valid}), 64'({4'b0010, 1'b0}));
    @(negedge clk);
    check("t1_n2_out", 64'({m_valid, m_src, m_last}), 64'({1'b1, 2'd1, 1'b0}));
    @(negedge clk);
    check("t1_n3_out", 64'({m_valid, m_last}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    check("t1_n4_out", 64'({m_valid, m_last, req[1]}), 64'({1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    check("t1_n5_req", 64'({m_valid, req[1]}), 64'd0);
    @(negedge clk);
    check("t1_n6_req", 64'(req[1]), 64'd1);

    // Multi-hot grant: lowest bit owns the lock.
    add_packet(2, 2);
    repeat (2) @(posedge clk);
    #2 grant = 4'b0110;
    @(posedge clk); #2 grant = '0;
    @(negedge clk);
    check("t4_ready", 64'(c_ready), 64'(4'b0010));
    @(negedge clk);
    check("t4_src", 64'({m_valid, m_src}), 64'({1'b1, 2'd1}));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_no_c2", 64'(c_ready[2]), 64'd0);
    end

    // Randomized traffic through the bench arbiter, including an over-long packet.
    add_packet(0, 10);
    for (int c = 0; c < N; c++)
      for (int p = 0; p < 6; p++) add_packet(c, $urandom_range(12, 1));
    bub_en = 1'b1; mr_mode = 1; use_arb = 1'b1;
    cyc = 0;
    while (!all_empty() && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_in_time", 64'(cyc < 20000), 64'd1);
    repeat (5) @(negedge clk);
    check("trunc_count", 64'(seen_trunc), 64'(exp_trunc));

    // Stall output for 5 cycles mid-packet, then reset asynchronously.
    use_arb = 1'b0; bub_en = 1'b0; mr_mode = 2;
    #1 grant = '0;
    repeat (5) @(negedge clk);
    add_packet(0, 4);
    repeat (2) @(posedge clk);
    #2 grant = 4'b0001;
    @(posedge clk); #2 grant = '0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_stall", 64'({m_valid, c_ready, m_data}), 64'({1'b1, 4'b0000, eq[0][0].data}));
    end
    sb_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out", 64'({m_valid, m_data, m_last, m_src, trunc_err}), 64'd0);
    check("t5_rst_hs", 64'({c_ready, req}), 64'd0);
    for (int i = 0; i < N; i++) begin
      cq[i].delete();
      eq[i].delete();
      pos[i] = 0;
    end
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_idle", 64'({c_ready, m_valid}), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
